// File: rtl/bcd_digit_serial_adder_if.sv
// Operand/result handshake bundle for the digit-serial BCD adder.
// Ports: in_valid/in_ready/a_bcd/b_bcd/cin (operand side), out_valid/out_ready/sum_bcd/cout
//        (result side), err when BCD_INPUT_CHECK_EN is defined. master = producer/consumer, slave = adder.
interface bcd_digit_serial_adder_if #(
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   a_bcd;
    logic [4*DIGITS-1:0]   b_bcd;
    logic                  cin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   sum_bcd;
    logic                  cout;
`ifdef BCD_INPUT_CHECK_EN
    logic                  err;
`endif

    modport master (
`ifdef BCD_INPUT_CHECK_EN
        input  err,
`endif
        output in_valid, a_bcd, b_bcd, cin, out_ready,
        input  in_ready, out_valid, sum_bcd, cout
    );

    modport slave (
`ifdef BCD_INPUT_CHECK_EN
        output err,
`endif
        input  in_valid, a_bcd, b_bcd, cin, out_ready,
        output in_ready, out_valid, sum_bcd, cout
    );
endinterface

// File: rtl/bcd_digit_serial_adder.sv
// Multi-digit packed-BCD adder, one digit per clock, LSD first; latency DIGITS clocks accept->out_valid.
// Ports: clk, rst_n (async active-low), bus (slave modport: operand and result valid/ready).
// Backpressure: holds result in DONE while out_ready=0; in_ready=0 from accept until after handshake.
// Optional macro BCD_INPUT_CHECK_EN adds the err output flagging non-BCD operand nibbles.
module bcd_digit_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bcd_digit_serial_adder_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    acc;
    logic [W-1:0]    sum_reg;
    logic [IW-1:0]   idx;
    logic            carry;
    logic            cout_reg;
    logic            in_ready_reg;
    logic            out_valid_reg;

    logic [4:0]      digit_sum;
    logic [4:0]      digit_adj;
    logic            digit_cy;
    logic [3:0]      digit_out;
    logic [W-1:0]    acc_next;

    // Operands are shifted right each RUN cycle, so the active digit is always
    // in [3:0]; result digits enter at the top of acc and drift down, landing
    // digit 0 in [3:0] after DIGITS shifts.
    always_comb begin
        digit_sum = {1'b0, a_reg[3:0]} + {1'b0, b_reg[3:0]} + {4'b0000, carry};
        digit_adj = digit_sum + 5'd6;
        digit_cy  = (digit_sum > 5'd9);
        digit_out = digit_cy ? digit_adj[3:0] : digit_sum[3:0];
        acc_next  = W'({digit_out, acc} >> 4);
    end

`ifdef BCD_INPUT_CHECK_EN
    logic err_pending;
    logic err_reg;

    function automatic logic has_bad_nibble(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    assign bus.err = err_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            acc           <= '0;
            sum_reg       <= '0;
            idx           <= '0;
            carry         <= 1'b0;
            cout_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
`ifdef BCD_INPUT_CHECK_EN
            err_pending   <= 1'b0;
            err_reg       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready_reg) begin
                        a_reg        <= bus.a_bcd;
                        b_reg        <= bus.b_bcd;
                        carry        <= bus.cin;
                        acc          <= '0;
                        idx          <= '0;
                        in_ready_reg <= 1'b0;
                        state        <= RUN;
`ifdef BCD_INPUT_CHECK_EN
                        err_pending  <= has_bad_nibble(bus.a_bcd) | has_bad_nibble(bus.b_bcd);
`endif
                    end
                end
                RUN: begin
                    a_reg <= a_reg >> 4;
                    b_reg <= b_reg >> 4;
                    carry <= digit_cy;
                    acc   <= acc_next;
                    idx   <= idx + 1'b1;
                    // Result registers are only loaded on the final digit, so
                    // partial sums never reach sum_bcd.
                    if (idx == LAST) begin
                        sum_reg       <= acc_next;
                        cout_reg      <= digit_cy;
                        out_valid_reg <= 1'b1;
                        idx           <= '0;
                        state         <= DONE;
`ifdef BCD_INPUT_CHECK_EN
                        err_reg       <= err_pending;
`endif
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state         <= IDLE;
`ifdef BCD_INPUT_CHECK_EN
                        err_reg       <= 1'b0;
`endif
                    end
                end
                default: begin
                    state         <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.sum_bcd   = sum_reg;
    assign bus.cout      = cout_reg;
endmodule
